// File: rtl/conv_window_feeder.sv
// conv_window_feeder: streams kernel-weighted 3x3 window columns of a stored frame to the accumulator stage
module conv_window_feeder #(
    parameter int IMG_W = 34,
    parameter int IMG_H = 34
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           img_we,
    input  logic [$clog2(IMG_W*IMG_H)-1:0] img_addr,
    input  logic [7:0]                     img_data,
    input  logic                           k_we,
    input  logic [3:0]                     k_addr,
    input  logic [7:0]                     k_data,
    input  logic                           start,
    output logic [15:0]                    din1,
    output logic [15:0]                    din2,
    output logic [15:0]                    din3,
    output logic [1:0]                     addr,
    output logic                           enable,
    output logic                           endSign,
    output logic                           busy,
    output logic                           done
);
    localparam int AW = $clog2(IMG_W*IMG_H);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [1:0]    kc_q, kc_d;
    logic [15:0]   din1_q, din1_d, din2_q, din2_d, din3_q, din3_d;
    logic [1:0]    addr_q, addr_d;
    logic          enable_q, enable_d, end_q, end_d, done_q, done_d;
    logic [7:0]    img_mem [IMG_W*IMG_H];
    logic [7:0]    k_q [9];
    logic [AW-1:0] pa0, pa1, pa2;
    logic [3:0]    ki;
    logic          idle, run, last_k, last_c, last_r;

    assign idle   = state_q == IDLE;
    assign run    = state_q == RUN;
    assign last_k = kc_q == 2'd2;
    assign last_c = c_q == CW'(IMG_W-3);
    assign last_r = r_q == RW'(IMG_H-3);
    assign pa0    = AW'(r_q) * AW'(IMG_W) + AW'(c_q) + AW'(kc_q);
    assign pa1    = pa0 + AW'(IMG_W);
    assign pa2    = pa0 + AW'(2*IMG_W);
    assign ki     = {2'b00, kc_q};

    // Host writes only land while idle so a pass always sees a stable frame and kernel
    always_ff @(posedge clk) begin
        if (img_we && idle && {1'b0, img_addr} < (AW+1)'(IMG_W*IMG_H))
            img_mem[img_addr] <= img_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) k_q[i] <= '0;
        end else if (k_we && idle && k_addr < 4'd9) begin
            k_q[k_addr] <= k_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            kc_q     <= '0;
            din1_q   <= '0;
            din2_q   <= '0;
            din3_q   <= '0;
            addr_q   <= '0;
            enable_q <= 1'b0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            kc_q     <= kc_d;
            din1_q   <= din1_d;
            din2_q   <= din2_d;
            din3_q   <= din3_d;
            addr_q   <= addr_d;
            enable_q <= enable_d;
            end_q    <= end_d;
            done_q   <= done_d;
        end
    end

    // Counters rest at zero outside RUN, so the first beat after start is window (0,0) column 0
    always_comb begin
        state_d  = idle ? (start ? RUN : IDLE) :
                   run  ? (last_k && last_c && last_r ? DONE : RUN) : IDLE;
        kc_d     = run && !last_k ? kc_q + 2'd1 : 2'd0;
        c_d      = !run ? '0 : !last_k ? c_q : last_c ? '0 : c_q + CW'(1);
        r_d      = !run ? '0 : !(last_k && last_c) ? r_q : last_r ? '0 : r_q + RW'(1);
        din1_d   = run ? {8'd0, img_mem[pa0]} * {8'd0, k_q[ki]} : '0;
        din2_d   = run ? {8'd0, img_mem[pa1]} * {8'd0, k_q[ki + 4'd3]} : '0;
        din3_d   = run ? {8'd0, img_mem[pa2]} * {8'd0, k_q[ki + 4'd6]} : '0;
        addr_d   = run ? kc_q : 2'd0;
        enable_d = run && last_k;
        end_d    = run && last_k && last_c && last_r;
        done_d   = state_q == DONE;
    end

    assign din1    = din1_q;
    assign din2    = din2_q;
    assign din3    = din3_q;
    assign addr    = addr_q;
    assign enable  = enable_q;
    assign endSign = end_q;
    assign busy    = !idle;
    assign done    = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: scoreboard bench for the default 34x34 feeder plus a 3x3 instance
module tb_conv_window_feeder;
    localparam int W  = 34;
    localparam int H  = 34;
    localparam int N  = (W-2)*(H-2);
    localparam int AW = $clog2(W*H);

    typedef struct packed {
        logic [15:0] d1, d2, d3;
        logic [1:0]  a;
        logic        en, es, bz, dn;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, img_we = 1'b0, k_we = 1'b0, start = 1'b0;
    logic [AW-1:0] img_addr = '0;
    logic [7:0]    img_data = '0, k_data = '0;
    logic [3:0]    k_addr = '0;
    logic [15:0]   din1, din2, din3;
    logic [1:0]    addr;
    logic          enable, endSign, busy, done;

    logic          s_img_we = 1'b0, s_k_we = 1'b0, s_start = 1'b0;
    logic [3:0]    s_img_addr = '0, s_k_addr = '0;
    logic [7:0]    s_img_data = '0, s_k_data = '0;
    logic [15:0]   s_din1, s_din2, s_din3;
    logic [1:0]    s_addr;
    logic          s_enable, s_endSign, s_busy, s_done;

    beat_t      q[$];
    logic [7:0] img_m [W*H];
    logic [7:0] k_m [9];
    int         checks = 0, failures = 0;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
        .k_we(k_we), .k_addr(k_addr), .k_data(k_data), .start(start),
        .din1(din1), .din2(din2), .din3(din3), .addr(addr), .enable(enable),
        .endSign(endSign), .busy(busy), .done(done)
    );

    conv_window_feeder #(.IMG_W(3), .IMG_H(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .img_we(s_img_we), .img_addr(s_img_addr), .img_data(s_img_data),
        .k_we(s_k_we), .k_addr(s_k_addr), .k_data(s_k_data), .start(s_start),
        .din1(s_din1), .din2(s_din2), .din3(s_din3), .addr(s_addr), .enable(s_enable),
        .endSign(s_endSign), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur();
        return {din1, din2, din3, addr, enable, endSign, busy, done};
    endfunction

    function automatic beat_t s_cur();
        return {s_din1, s_din2, s_din3, s_addr, s_enable, s_endSign, s_busy, s_done};
    endfunction

    task automatic fill_img(input int mode);
        logic [7:0] v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                v = mode == 0 ? 8'd1 : mode == 1 ? 8'((r + c) % 256) : 8'd255;
                @(negedge clk);
                img_we = 1'b1; img_addr = AW'(r*W + c); img_data = v;
                img_m[r*W + c] = v;
            end
        end
        @(negedge clk);
        img_we = 1'b0;
    endtask

    task automatic set_k(input int mode);
        logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            v = mode == 0 ? 8'd1 : mode == 1 ? (i == 4 ? 8'd2 : 8'd0) : mode == 2 ? 8'd255 : 8'(i + 1);
            @(negedge clk);
            k_we = 1'b1; k_addr = 4'(i); k_data = v;
            k_m[i] = v;
        end
        @(negedge clk);
        k_addr = 4'd12; k_data = 8'd99;
        @(negedge clk);
        k_we = 1'b0;
    endtask

    task automatic push_pass();
        beat_t b;
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++)
                for (int kc = 0; kc < 3; kc++) begin
                    b.d1 = 16'(img_m[r*W + c + kc]) * 16'(k_m[kc]);
                    b.d2 = 16'(img_m[(r+1)*W + c + kc]) * 16'(k_m[3 + kc]);
                    b.d3 = 16'(img_m[(r+2)*W + c + kc]) * 16'(k_m[6 + kc]);
                    b.a  = 2'(kc);
                    b.en = kc == 2;
                    b.es = kc == 2 && r == H-3 && c == W-3;
                    b.bz = 1'b1;
                    b.dn = 1'b0;
                    q.push_back(b);
                end
    endtask

    task automatic run_pass(input bit wr0, input int mid_j, input int abort_j);
        beat_t exp;
        int    ne, ns;
        if (wr0) img_m[0] = 8'd200;
        push_pass();
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin img_we = 1'b1; img_addr = '0; img_data = 8'd200; end
        @(posedge clk);
        #1 start = 1'b0; img_we = 1'b0;
        @(negedge clk);
        chk("busy_at_start", {busy, din1, addr, enable}, {1'b1, 16'd0, 2'd0, 1'b0});
        ne = 0; ns = 0;
        for (int j = 0; j < 3*N; j++) begin
            @(negedge clk);
            exp = q.size() > 0 ? q.pop_front() : '0;
            chk($sformatf("beat%0d", j), cur(), exp);
            ne += int'(enable); ns += int'(endSign);
            if (j == abort_j) begin
                #2 rst_n = 1'b0;
                #1 chk("abort_outputs", cur(), '0);
                q.delete();
                for (int i = 0; i < 9; i++) k_m[i] = 8'd0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("abort_no_done", {busy, done}, 2'b00);
                end
                return;
            end
            if (j == mid_j) begin
                img_we = 1'b1; img_addr = AW'(2*W + 5); img_data = 8'hAA;
                k_we = 1'b1; k_addr = 4'd0; k_data = 8'd77;
                start = 1'b1;
                @(posedge clk);
                #1 img_we = 1'b0; k_we = 1'b0; start = 1'b0;
            end
        end
        chk("enable_count", 64'(ne), 64'(N));
        chk("endsign_count", 64'(ns), 64'd1);
        @(negedge clk);
        chk("done_pulse", cur(), beat_t'({48'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        chk("done_fall", {busy, done}, 2'b00);
    endtask

    initial begin
        beat_t b;
        repeat (3) @(negedge clk);
        chk("reset_outputs", cur(), '0);
        chk("reset_outputs_small", s_cur(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", cur(), '0);

        fill_img(0); set_k(0); run_pass(1'b1, -1, -1);
        fill_img(1); set_k(1); run_pass(1'b0, -1, -1);
        fill_img(2); set_k(2); run_pass(1'b0, -1, -1);
        fill_img(1); set_k(3); run_pass(1'b0, 10, -1);
        run_pass(1'b0, -1, 500);
        run_pass(1'b0, -1, -1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s_k_we = 1'b1; s_k_addr = 4'(i); s_k_data = 8'(i + 1);
            s_img_we = 1'b1; s_img_addr = 4'(i); s_img_data = 8'd1;
        end
        @(negedge clk);
        s_k_we = 1'b0; s_img_we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            b = {16'(j + 1), 16'(j + 4), 16'(j + 7), 2'(j), j == 2, j == 2, 1'b1, 1'b0};
            q.push_back(b);
        end
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        @(negedge clk);
        chk("small_busy_start", {s_busy, s_enable}, 2'b10);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            b = q.size() > 0 ? q.pop_front() : '0;
            chk($sformatf("small_beat%0d", j), s_cur(), b);
        end
        @(negedge clk);
        chk("small_done", s_cur(), beat_t'({48'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        chk("small_done_fall", {s_busy, s_done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of the 3x3 convolution accumulator. Holds one 8-bit image frame and a 3x3 8-bit kernel, then on `start` walks every valid 3x3 window in raster order. For each window it emits three column beats of kernel-weighted products on `din1`/`din2`/`din3` with column index `addr`. It flags the last beat of each window with `enable` and the last beat of the frame with `endSign`. Outputs connect port-for-port to the downstream adder stage (`din1..3`, `addr`, `enable`, `endSign_in`).

## Interface
- `IMG_W`, 34, image width in pixels (≥3)
- `IMG_H`, 34, image height in pixels (≥3); default yields (34-2)*(34-2)=1024 windows
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `img_we`  in  1  image write strobe
- `img_addr`  in  clog2(IMG_W*IMG_H)  linear pixel address, row*IMG_W+col
- `img_data`  in  8  pixel, unsigned
- `k_we`  in  1  kernel write strobe
- `k_addr`  in  4  kernel index 0..8, row-major (k[3*row+col]); 9..15 ignored
- `k_data`  in  8  weight, unsigned
- `start`  in  1  begin frame pass (level sampled in IDLE)
- `din1`  out  16  img[r][c+addr]*k[addr]
- `din2`  out  16  img[r+1][c+addr]*k[3+addr]
- `din3`  out  16  img[r+2][c+addr]*k[6+addr]
- `addr`  out  2  kernel column of current beat, 0,1,2
- `enable`  out  1  high on addr=2 beat of every window
- `endSign`  out  1  high on addr=2 beat of last window only
- `busy`  out  1  high while pass in progress
- `done`  out  1  one-cycle pulse after last beat

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: host writes accepted. `start`=1 at an edge → RUN.
- RUN: counters `r` in 0..IMG_H-3, `c` in 0..IMG_W-3, `kc` in 0..2. `kc` increments each cycle. When `kc` wraps, `c` increments. When `c` wraps, `r` increments. After beat (IMG_H-3, IMG_W-3, 2) → DONE.
- DONE: one cycle with `done`=1, then → IDLE.
- Products: 8x8 unsigned → 16-bit exact, no truncation. Max 255*255=65025. Sum overflow is a downstream concern.
- Outputs are registered. Outside RUN beats, `din1..3`=0, `addr`=0, `enable`=0, `endSign`=0.
- Writes to `img_*` / `k_*` while `busy`=1 are ignored. `start` while busy is ignored.
- Simultaneous `img_we` and `start` in IDLE: write commits, and the pass uses the new value.
- Reset values: all outputs 0, FSM IDLE, counters 0, kernel registers 0. Image memory is not reset (contents undefined until written).
- Reset mid-pass: immediate abort. Outputs go to 0 asynchronously, FSM goes to IDLE, and no `done` pulse is issued.

## Timing
- N = (IMG_W-2)*(IMG_H-2) windows, 3N beats.
- `start` is sampled at edge E. `busy`=1 from E through E+3N.
- Beat j (j=0..3N-1) is valid from edge E+1+j to E+2+j. Window i = j/3, `addr`=j%3.
- One beat per cycle, with no gaps or bubbles between windows.
- `enable` is high for cycles where j%3=2. `endSign` is high only for j=3N-1.
- Edge E+3N+1: outputs return to 0, `busy`=0, `done`=1 for one cycle.
- Earliest next `start` is sampled at edge E+3N+2.
- Downstream latches `addr`/`din` and `enable` on the same edge, so its sum is valid one cycle after each `enable` beat.
- Host writes take effect at the edge they are sampled on. A write at edge E-1 is visible to beat 0.

## Test plan
- All pixels=1, all weights=1, start → 3072 beats with `din1..3`=1. `enable` high on every third beat (1024 times). Single `endSign` on beat 3071. `done` one cycle after the last beat.
- Pixel(r,c)=(r+c)%256; only k[4]=2; start → window (r,c) addr=1 beat gives din2=2*((r+1+c+1)%256). `din1`, `din3`, and all addr 0/2 beats are 0.
- All pixels=255, all weights=255 → every din=65025. Confirms no truncation.
- With IMG_W=IMG_H=3: k=1..9, pixel(r,c)=1 → beats (din1,din2,din3) = (1,4,7), (2,5,8), (3,6,9). `enable` and `endSign` both high on beat 2. `busy` lasts 3 beats.
- Mid-pass: change image and kernel writes and assert `start` at beat 10 → no effect on remaining beats. The pass completes with original data.
- Assert `rst_n`=0 at beat 500 → outputs 0 immediately and no `done`. After release, kernel reads 0. A new start yields all-zero `din` with a correct `enable`/`endSign` pattern.
